// File: rtl/conv_result_collector_if.sv
// ---------------------------------------------------------------------------
// conv_result_collector_if
//   Groups the signals of conv_result_collector into one interface.
//   The collector takes the master modport. A downstream model or the
//   kernel-array side takes the slave modport.
//
//   Kernel side (into the collector):
//     i_pixel_bus    ARRAY_SIZE*DATA_WIDTH  result bus; element 0 in MSB slice
//     i_window_done  1                      one-cycle window-finished marker
//     i_flush        1                      synchronous flush
//   Stream side:
//     i_ready        1                      downstream ready
//     o_data         DATA_WIDTH             current element
//     o_valid        1                      o_data valid
//     o_index        IDX_W                  element index of o_data
//     o_last         1                      high with element ARRAY_SIZE-1
//     o_overflow     1                      sticky: a snapshot was dropped
//   Debug:
//     dbg_state      1                      collector FSM state (0 idle, 1 drain)
//
//   Handshake: an element moves on every rising clk edge where o_valid and
//   i_ready are both high. While o_valid is high and i_ready is low, the
//   o_data, o_index and o_last outputs hold their values. o_valid never
//   drops without a transfer, except on flush or reset.
// ---------------------------------------------------------------------------
interface conv_result_collector_if #(
  parameter int ARRAY_SIZE = 6,
  parameter int DATA_WIDTH = 32
);
  localparam int IDX_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;

  logic [ARRAY_SIZE*DATA_WIDTH-1:0] i_pixel_bus;
  logic                             i_window_done;
  logic                             i_flush;
  logic                             i_ready;
  logic [DATA_WIDTH-1:0]            o_data;
  logic                             o_valid;
  logic [IDX_W-1:0]                 o_index;
  logic                             o_last;
  logic                             o_overflow;
  logic                             dbg_state;

  modport master (
    input  i_pixel_bus, i_window_done, i_flush, i_ready,
    output o_data, o_valid, o_index, o_last, o_overflow, dbg_state
  );

  modport slave (
    output i_pixel_bus, i_window_done, i_flush, i_ready,
    input  o_data, o_valid, o_index, o_last, o_overflow, dbg_state
  );
endinterface

// File: rtl/conv_result_collector.sv
// ---------------------------------------------------------------------------
// conv_result_collector
//   Snapshots the kernel array's parallel result bus CAPTURE_DELAY cycles
//   after each window-done marker. It then serialises the snapshot one
//   element per valid/ready transfer.
//
//   Storage:
//     - One drain register, which is the snapshot being streamed.
//     - One pending register, which lets back-to-back windows stream
//       without a bubble.
//   If neither slot can take a capture, the snapshot is dropped and
//   o_overflow is set. o_overflow is sticky.
//
//   Ports:
//     clk    clock
//     rst_n  asynchronous active-low reset
//     bus    conv_result_collector_if.master (see the interface file for the
//            signal list and the handshake rules)
// ---------------------------------------------------------------------------
module conv_result_collector #(
  parameter int ARRAY_SIZE    = 6,
  parameter int DATA_WIDTH    = 32,
  parameter int CAPTURE_DELAY = 3   // legal range 1..8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  conv_result_collector_if.master       bus
);

  localparam int               IDX_W    = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ARRAY_SIZE - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      pend_full_q, pend_full_d;
  logic                      ovf_q, ovf_d;
  logic [CAPTURE_DELAY-1:0]  dly_q, dly_d;
  logic [CAPTURE_DELAY:0]    dly_ext;

  logic [DATA_WIDTH-1:0]     drain_q [ARRAY_SIZE];
  logic [DATA_WIDTH-1:0]     pend_q  [ARRAY_SIZE];
  logic [DATA_WIDTH-1:0]     snap    [ARRAY_SIZE];

  logic capture;
  logic valid;
  logic xfer;
  logic last_xfer;
  logic drain_free;
  logic pend_moves;
  logic load_drain_snap;
  logic load_drain_pend;
  logic load_pend;

  // Unpack the bus. Element 0 is in the most significant slice.
  always_comb begin
    for (int k = 0; k < ARRAY_SIZE; k++) begin
      snap[k] = bus.i_pixel_bus[(ARRAY_SIZE-1-k)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // The marker pulse walks through the delay line.
  // A 1 in the top bit means the bus holds the final sums in this cycle.
  assign dly_ext = {dly_q, bus.i_window_done};
  assign capture = dly_q[CAPTURE_DELAY-1];

  assign valid      = (state_q == ST_DRAIN);
  assign xfer       = valid && bus.i_ready;
  assign last_xfer  = xfer && (idx_q == LAST_IDX);
  // The drain slot is free after this edge if it is empty now, or if its
  // final element leaves on this edge.
  assign drain_free = (state_q == ST_IDLE) || last_xfer;
  assign pend_moves = last_xfer && pend_full_q;

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    pend_full_d     = pend_full_q;
    ovf_d           = ovf_q;
    dly_d           = dly_ext[CAPTURE_DELAY-1:0];
    load_drain_snap = 1'b0;
    load_drain_pend = 1'b0;
    load_pend       = 1'b0;

    if (bus.i_flush) begin
      // Flush wins over any transfer or capture on the same edge.
      state_d     = ST_IDLE;
      idx_d       = '0;
      pend_full_d = 1'b0;
      ovf_d       = 1'b0;
      dly_d       = '0;
    end else begin
      if (xfer) begin
        if (idx_q == LAST_IDX) begin
          idx_d = '0;
          if (pend_full_q) begin
            load_drain_pend = 1'b1;
            pend_full_d     = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      if (capture) begin
        if (drain_free && !pend_full_q) begin
          load_drain_snap = 1'b1;
          state_d         = ST_DRAIN;
          idx_d           = '0;
        end else if (!pend_full_q || pend_moves) begin
          // If pending moves into drain on this edge, the new snapshot
          // refills pending, so pending stays full.
          load_pend   = 1'b1;
          pend_full_d = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      pend_full_q <= 1'b0;
      ovf_q       <= 1'b0;
      dly_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pend_full_q <= pend_full_d;
      ovf_q       <= ovf_d;
      dly_q       <= dly_d;
    end
  end

  // Data slots.
  // load_drain_snap needs pending to be empty and load_drain_pend needs it
  // full, so the two never fire together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < ARRAY_SIZE; k++) begin
        drain_q[k] <= '0;
        pend_q[k]  <= '0;
      end
    end else begin
      if (load_drain_snap) begin
        drain_q <= snap;
      end else if (load_drain_pend) begin
        drain_q <= pend_q;
      end
      if (load_pend) begin
        pend_q <= snap;
      end
    end
  end

  assign bus.o_valid    = valid;
  assign bus.o_data     = valid ? drain_q[idx_q] : '0;
  assign bus.o_index    = idx_q;
  assign bus.o_last     = valid && (idx_q == LAST_IDX);
  assign bus.o_overflow = ovf_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_conv_result_collector.sv
module tb_conv_result_collector;

  localparam int N     = 6;
  localparam int W     = 32;
  localparam int D     = 3;
  localparam int IDX_W = $clog2(N);

  logic clk;
  logic rst_n;

  conv_result_collector_if #(.ARRAY_SIZE(N), .DATA_WIDTH(W)) ifc ();

  conv_result_collector #(
    .ARRAY_SIZE   (N),
    .DATA_WIDTH   (W),
    .CAPTURE_DELAY(D)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc.master)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_cmp;
  int n_bad;

  logic [W-1:0] exp_q[$];
  int           exp_idx_q[$];

  // Reference model: elements still owed downstream, pending capture times,
  // sticky drop flag.
  int cyc;
  int outstanding;
  bit m_ovf;
  int due_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N*W-1:0] pack_bus(input logic [W-1:0] e [N]);
    logic [N*W-1:0] b;
    for (int k = 0; k < N; k++) b[(N-1-k)*W +: W] = e[k];
    return b;
  endfunction

  function automatic logic [N*W-1:0] pattern_bus(input logic [W-1:0] base);
    logic [W-1:0] e [N];
    for (int k = 0; k < N; k++) e[k] = base * W'(k + 1);
    return pack_bus(e);
  endfunction

  function automatic logic [N*W-1:0] random_bus();
    logic [W-1:0] e [N];
    for (int k = 0; k < N; k++) e[k] = $urandom;
    return pack_bus(e);
  endfunction

  // ---------------- model ----------------
  // Runs just after the falling edge, when this cycle's inputs are stable,
  // and computes what the next rising edge does.
  // A capture is kept when fewer than two windows are still owed after
  // this edge's transfer.
  always @(negedge clk) begin
    int held;
    logic [W-1:0] e;
    #1;
    if (!rst_n) begin
      exp_q.delete();
      exp_idx_q.delete();
      due_q.delete();
      outstanding = 0;
      m_ovf = 1'b0;
    end else begin
      check("valid", {31'd0, ifc.o_valid}, {31'd0, outstanding > 0});
      check("overflow", {31'd0, ifc.o_overflow}, {31'd0, m_ovf});
      if (ifc.i_flush) begin
        exp_q.delete();
        exp_idx_q.delete();
        due_q.delete();
        outstanding = 0;
        m_ovf = 1'b0;
      end else begin
        if (outstanding > 0 && ifc.i_ready) outstanding--;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
          void'(due_q.pop_front());
          held = (outstanding + N - 1) / N;
          if (held < 2) begin
            for (int k = 0; k < N; k++) begin
              e = ifc.i_pixel_bus[(N-1-k)*W +: W];
              exp_q.push_back(e);
              exp_idx_q.push_back(k);
            end
            outstanding += N;
          end else begin
            m_ovf = 1'b1;
          end
        end
        if (ifc.i_window_done) due_q.push_back(cyc + D);
      end
    end
    cyc++;
  end

  // ---------------- monitor ----------------
  // While o_valid is high, the head of the expected queue must be shown.
  // An element is retired only when it is transferred.
  always @(negedge clk) begin
    int ei;
    if (rst_n && ifc.o_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", {31'd0, ifc.o_valid}, 32'd0);
      end else begin
        ei = exp_idx_q[0];
        check("data", ifc.o_data, exp_q[0]);
        check("index", W'(ifc.o_index), W'(ei));
        check("last", {31'd0, ifc.o_last}, {31'd0, ei == N - 1});
        if (ifc.i_ready && !ifc.i_flush) begin
          void'(exp_q.pop_front());
          void'(exp_idx_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input bit done, input bit rdy, input bit fl, input logic [N*W-1:0] b);
    ifc.i_window_done = done;
    ifc.i_ready       = rdy;
    ifc.i_flush       = fl;
    ifc.i_pixel_bus   = b;
    @(posedge clk);
    #1;
  endtask

  task automatic drain_all();
    int budget;
    budget = 0;
    while ((outstanding > 0 || due_q.size() > 0) && budget < 200) begin
      drive(1'b0, 1'b1, 1'b0, ifc.i_pixel_bus);
      budget++;
    end
    check("drain_timeout", W'(budget >= 200), 32'd0);
    drive(1'b0, 1'b1, 1'b0, ifc.i_pixel_bus);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, {31'd0, ifc.o_valid}, 32'd0);
    check({tag, "_data"}, ifc.o_data, 32'd0);
    check({tag, "_index"}, W'(ifc.o_index), 32'd0);
    check({tag, "_last"}, {31'd0, ifc.o_last}, 32'd0);
    check({tag, "_overflow"}, {31'd0, ifc.o_overflow}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [N*W-1:0] bus_a;
    logic [N*W-1:0] bus_b;
    n_cmp = 0;
    n_bad = 0;
    cyc = 0;
    outstanding = 0;
    m_ovf = 1'b0;
    rst_n = 1'b0;
    ifc.i_window_done = 1'b0;
    ifc.i_ready = 1'b0;
    ifc.i_flush = 1'b0;
    ifc.i_pixel_bus = '0;
    bus_a = pattern_bus(32'h11);
    bus_b = pattern_bus(32'h11) + pattern_bus(32'h0);
    for (int k = 0; k < N; k++) bus_b[(N-1-k)*W +: W] = 32'hA1 + W'(k);

    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b0, '0);

    // Single window, ready always high.
    drive(1'b1, 1'b1, 1'b0, bus_a);
    repeat (3) drive(1'b0, 1'b1, 1'b0, bus_a);
    drain_all();

    // Backpressure on element 1.
    drive(1'b1, 1'b1, 1'b0, bus_a);
    repeat (4) drive(1'b0, 1'b1, 1'b0, bus_a);
    repeat (3) drive(1'b0, 1'b0, 1'b0, bus_a);
    drain_all();

    // Back-to-back windows: B lands in pending and follows A with no gap.
    drive(1'b1, 1'b1, 1'b0, bus_a);
    drive(1'b0, 1'b1, 1'b0, bus_a);
    drive(1'b1, 1'b1, 1'b0, bus_a);
    drive(1'b0, 1'b1, 1'b0, bus_a);
    repeat (4) drive(1'b0, 1'b1, 1'b0, bus_b);
    drain_all();

    // Overflow: three windows with no ready; the third is dropped.
    drive(1'b1, 1'b0, 1'b0, bus_a);
    drive(1'b0, 1'b0, 1'b0, bus_a);
    drive(1'b1, 1'b0, 1'b0, bus_a);
    drive(1'b0, 1'b0, 1'b0, bus_a);
    drive(1'b1, 1'b0, 1'b0, bus_a);
    repeat (2) drive(1'b0, 1'b0, 1'b0, bus_b);
    repeat (4) drive(1'b0, 1'b0, 1'b0, pattern_bus(32'h3C));
    drain_all();
    drive(1'b0, 1'b1, 1'b1, '0);
    drive(1'b0, 1'b1, 1'b0, '0);

    // Flush during a drain, with another marker still in the delay line.
    drive(1'b1, 1'b1, 1'b0, bus_a);
    repeat (2) drive(1'b0, 1'b1, 1'b0, bus_a);
    drive(1'b1, 1'b1, 1'b0, bus_a);
    repeat (2) drive(1'b0, 1'b1, 1'b0, bus_a);
    drive(1'b0, 1'b1, 1'b1, bus_b);
    repeat (6) drive(1'b0, 1'b1, 1'b0, bus_b);
    drain_all();

    // Asynchronous reset in the middle of a drain.
    drive(1'b1, 1'b1, 1'b0, bus_a);
    repeat (5) drive(1'b0, 1'b1, 1'b0, bus_a);
    #1;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, bus_b);
    repeat (3) drive(1'b0, 1'b1, 1'b0, bus_b);
    drain_all();

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      drive(($urandom_range(0, 3) == 0),
            ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 79) == 0),
            random_bus());
    end
    drain_all();

    check("leftover_expected", W'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
